midi_voice_allocator: RTL

Sits between the MIDI byte receiver and the per-voice stepper tone generators. It parses the received MIDI byte stream, which is strobed one byte at a time, and supports running status. It allocates Note On / Note Off events for one selected MIDI channel across NUM_VOICES stepper voices. Its outputs are registered per-voice note and velocity values plus active flags, which drive the downstream step-rate generators.

---
 rtl/midi_pkg.sv | 17 +
 rtl/midi_msg_parser.sv | 104 ++++++++++
 rtl/midi_voice_allocator.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state and command encodings for the voice allocator.
package midi_pkg;

   localparam logic [3:0] ST_NOTE_OFF = 4'h8;
   localparam logic [3:0] ST_NOTE_ON  = 4'h9;
   localparam logic [3:0] ST_CC       = 4'hB;
   localparam logic [3:0] ST_PROG     = 4'hC;
   localparam logic [3:0] ST_CHPRESS  = 4'hD;

   localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
   localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

   typedef enum logic [1:0] {PS_IDLE, PS_DATA1, PS_DATA2} parse_state_e;

   typedef enum logic [1:0] {CMD_NONE, CMD_ON, CMD_OFF, CMD_ALL_OFF} cmd_e;

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: byte classifier, running-status FSM and channel filter.
// Emits one registered command per completed message with a single-cycle valid.
module midi_msg_parser
   import midi_pkg::*;
#(
   parameter int MIDI_CHANNEL = 0,
   parameter int OMNI         = 0
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_rx_byte,
   input  logic       i_rx_valid,
   output cmd_e       o_cmd,
   output logic [6:0] o_note,
   output logic [6:0] o_vel,
   output logic       o_vld
);
   parse_state_e r_state, w_state_nx;
   logic [7:0]   r_status, w_status_nx;
   logic [6:0]   r_d1, r_note, r_vel;
   cmd_e         r_cmd, w_cmd;
   logic         r_vld;
   logic         w_is_data, w_is_chan, w_is_sys, w_one_byte, w_complete, w_chan_ok;
   logic [6:0]   w_d1, w_d2;

   assign w_is_data  = i_rx_valid && !i_rx_byte[7];
   assign w_is_chan  = i_rx_valid && i_rx_byte[7] && (i_rx_byte[7:4] != 4'hF);
   assign w_is_sys   = i_rx_valid && (i_rx_byte[7:3] == 5'b11110);
   assign w_one_byte = (r_status[7:4] == ST_PROG) || (r_status[7:4] == ST_CHPRESS);
   assign w_chan_ok  = (OMNI != 0) || (r_status[3:0] == 4'(MIDI_CHANNEL));

   // Running status is part of the FSM state; realtime bytes match no class and change nothing.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= PS_IDLE;
         r_status <= '0;
      end else begin
         r_state  <= w_state_nx;
         r_status <= w_status_nx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_status_nx = r_status;
      if (w_is_sys) begin
         w_state_nx  = PS_IDLE;
         w_status_nx = '0;
      end else if (w_is_chan) begin
         w_state_nx  = PS_DATA1;
         w_status_nx = i_rx_byte;
      end else if (w_is_data) begin
         case (r_state)
            PS_DATA1: if (!w_one_byte) w_state_nx = PS_DATA2;
            PS_DATA2: w_state_nx = PS_DATA1;
            default:  w_state_nx = r_state;
         endcase
      end
   end

   always_comb begin
      w_complete = 1'b0;
      w_d1       = r_d1;
      w_d2       = '0;
      w_cmd      = CMD_NONE;
      if (w_is_data) begin
         if (r_state == PS_DATA1 && w_one_byte) begin
            w_complete = 1'b1;
            w_d1       = i_rx_byte[6:0];
         end else if (r_state == PS_DATA2) begin
            w_complete = 1'b1;
            w_d2       = i_rx_byte[6:0];
         end
      end
      if (w_complete && w_chan_ok) begin
         case (r_status[7:4])
            ST_NOTE_ON:  w_cmd = (w_d2 != 7'd0) ? CMD_ON : CMD_OFF;
            ST_NOTE_OFF: w_cmd = CMD_OFF;
            ST_CC: begin
               if (w_d1 == CC_ALL_SOUND_OFF || w_d1 == CC_ALL_NOTES_OFF) w_cmd = CMD_ALL_OFF;
            end
            default:     w_cmd = CMD_NONE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_is_data && r_state == PS_DATA1) r_d1 <= i_rx_byte[6:0];
   end

   always_ff @(posedge i_clk) begin
      r_cmd  <= w_cmd;
      r_note <= w_d1;
      r_vel  <= w_d2;
      if (i_rst) r_vld <= 1'b0;
      else       r_vld <= (w_cmd != CMD_NONE);
   end

   assign o_cmd  = r_cmd;
   assign o_note = r_note;
   assign o_vel  = r_vel;
   assign o_vld  = r_vld;

endmodule

// File: rtl/midi_voice_allocator.sv
// Voice table and Note On/Off allocation fed by midi_msg_parser.
// Define VOICE_STEAL_EN to overwrite the voice at a rotating steal pointer when all voices are busy.
module midi_voice_allocator
   import midi_pkg::*;
#(
   parameter int NUM_VOICES   = 8,
   parameter int MIDI_CHANNEL = 0,
   parameter int OMNI         = 0
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [7:0]              i_rx_byte,
   input  logic                    i_rx_valid,
   output logic [NUM_VOICES-1:0]   o_voice_active,
   output logic [7*NUM_VOICES-1:0] o_voice_note,
   output logic [7*NUM_VOICES-1:0] o_voice_vel,
   output logic                    o_note_event,
   output logic                    o_dropped
);
   localparam int IW = $clog2(NUM_VOICES);

   cmd_e                  w_cmd;
   logic                  w_cmd_vld;
   logic [6:0]            w_cmd_note, w_cmd_vel;
   logic [NUM_VOICES-1:0] r_active, w_active_nx;
   logic [6:0]            r_note    [NUM_VOICES];
   logic [6:0]            r_vel     [NUM_VOICES];
   logic [6:0]            w_note_nx [NUM_VOICES];
   logic [6:0]            w_vel_nx  [NUM_VOICES];
   logic                  w_hit, w_free, w_change, w_drop;
   logic [IW-1:0]         w_hit_idx, w_free_idx;
   logic                  r_note_event, r_dropped;
`ifdef VOICE_STEAL_EN
   logic [IW-1:0]         r_steal_ptr;
   logic                  w_steal;
`endif

   midi_msg_parser #(
      .MIDI_CHANNEL (MIDI_CHANNEL),
      .OMNI         (OMNI)
   ) u_parser (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_rx_byte  (i_rx_byte),
      .i_rx_valid (i_rx_valid),
      .o_cmd      (w_cmd),
      .o_note     (w_cmd_note),
      .o_vel      (w_cmd_vel),
      .o_vld      (w_cmd_vld)
   );

   // Descending scan so the lowest-index free voice wins; at most one active voice can match.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_idx  = '0;
      w_free     = 1'b0;
      w_free_idx = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (r_active[i] && r_note[i] == w_cmd_note) begin
            w_hit     = 1'b1;
            w_hit_idx = IW'(i);
         end
         if (!r_active[i]) begin
            w_free     = 1'b1;
            w_free_idx = IW'(i);
         end
      end
   end

   always_comb begin
      w_active_nx = r_active;
      w_note_nx   = r_note;
      w_vel_nx    = r_vel;
      w_drop      = 1'b0;
`ifdef VOICE_STEAL_EN
      w_steal     = 1'b0;
`endif
      if (w_cmd_vld) begin
         case (w_cmd)
            CMD_ON: begin
               if (w_hit) begin
                  w_vel_nx[w_hit_idx] = w_cmd_vel;
               end else if (w_free) begin
                  w_active_nx[w_free_idx] = 1'b1;
                  w_note_nx[w_free_idx]   = w_cmd_note;
                  w_vel_nx[w_free_idx]    = w_cmd_vel;
               end else begin
`ifdef VOICE_STEAL_EN
                  w_steal                 = 1'b1;
                  w_note_nx[r_steal_ptr]  = w_cmd_note;
                  w_vel_nx[r_steal_ptr]   = w_cmd_vel;
`else
                  w_drop = 1'b1;
`endif
               end
            end
            CMD_OFF:     if (w_hit) w_active_nx[w_hit_idx] = 1'b0;
            CMD_ALL_OFF: w_active_nx = '0;
            default:     w_active_nx = r_active;
         endcase
      end
   end

   always_comb begin
      w_change = (w_active_nx != r_active);
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (w_note_nx[i] != r_note[i] || w_vel_nx[i] != r_vel[i]) w_change = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_active     <= '0;
         r_note_event <= 1'b0;
         r_dropped    <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            r_note[i] <= '0;
            r_vel[i]  <= '0;
         end
      end else begin
         r_active     <= w_active_nx;
         r_note       <= w_note_nx;
         r_vel        <= w_vel_nx;
         r_note_event <= w_change;
         r_dropped    <= w_drop;
      end
   end

`ifdef VOICE_STEAL_EN
   always_ff @(posedge i_clk) begin
      if (i_rst)        r_steal_ptr <= '0;
      else if (w_steal) r_steal_ptr <= (r_steal_ptr == IW'(NUM_VOICES - 1)) ? '0 : r_steal_ptr + 1'b1;
   end
`endif

   always_comb begin
      for (int i = 0; i < NUM_VOICES; i++) begin
         o_voice_note[7*i +: 7] = r_note[i];
         o_voice_vel[7*i +: 7]  = r_vel[i];
      end
   end

   assign o_voice_active = r_active;
   assign o_note_event   = r_note_event;
   assign o_dropped      = r_dropped;

endmodule
